// File: rtl/e_strip_pkg.sv
// Shared types and constants for the byte-offset datapath (add side and strip side).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package e_pkg;

  typedef logic [7:0] byte_t;

  // Offset added upstream and removed here; one constant keeps both ends in step.
  localparam byte_t E_OFFSET = 8'h10;

  // Remove the datapath offset, modulo 256.
  function automatic byte_t strip_offset(input byte_t raw, input byte_t off);
    return raw - off;
  endfunction

endpackage

// File: rtl/e_strip_fifo.sv
// Elastic byte FIFO: storage, wrapping pointers and occupancy level.
// Latency: a push at edge N is visible at the head after edge N (no bypass).
// Backpressure: caller must gate push on level != DEPTH and pop on level != 0.
module e_strip_fifo
  import e_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  byte_t                  push_dat,
  input  logic                   pop,
  output byte_t                  head_dat,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  byte_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q,  level_d;

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state clears asynchronously so in-flight data is dropped at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; entries are meaningless while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_dat;
  end

  assign head_dat = mem[rd_ptr_q];
  assign level    = level_q;

endmodule

// File: rtl/e_strip.sv
// Strips the datapath offset from each received byte through an elastic FIFO, counting deliveries.
// Latency: one cycle from accepted input to out_valid; one byte/cycle sustained.
// Backpressure: in_ready = !full from registered state only; a full FIFO refuses push even when popping.
module e_strip
  import e_pkg::*;
#(
  parameter int    DEPTH  = 4,
  parameter byte_t OFFSET = E_OFFSET
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            byte_count
);

  localparam int             LW   = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0]  FULL = LW'(DEPTH);

  logic [1:0]    rst_sync_q, rst_sync_d;
  logic [15:0]   byte_count_q, byte_count_d;
  logic [LW-1:0] fifo_level;
  byte_t         head_dat;
  logic          push;
  logic          pop;

  // Handshake decode: flags come from registered level and the synchronised reset only.
  always_comb begin
    in_ready  = rst_sync_q[1] && (fifo_level != FULL);
    out_valid = (fifo_level != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Shift a one into the two-flop reset synchroniser; release is edge-aligned.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Asynchronous assert, synchronous release of the push enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  // Delivered-byte counter sticks at all-ones instead of wrapping.
  always_comb begin
    byte_count_d = byte_count_q;
    if (pop && (byte_count_q != 16'hFFFF)) byte_count_d = byte_count_q + 16'd1;
  end

  // Counter clears with reset like the rest of the control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) byte_count_q <= '0;
    else        byte_count_q <= byte_count_d;
  end

  e_strip_fifo #(
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (in_data),
    .pop      (pop),
    .head_dat (head_dat),
    .level    (fifo_level)
  );

  // The raw byte is stored; the offset is removed on the read side.
  assign out_data   = strip_offset(head_dat, OFFSET);
  assign level      = fifo_level;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_e_strip.sv
// Directed bench for e_strip with a queue scoreboard and an independent output monitor.
// Latency: stimulus acts 1 time unit after the rising edge; monitor samples on the falling edge.
// Backpressure: pushes are recorded only when in_ready was high before the accepting edge.
module tb_e_strip;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [2:0]  level;
  logic [15:0] byte_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  e_strip #(.DEPTH(4), .OFFSET(8'h10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .level      (level),
    .byte_count (byte_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pop the DUT performs is compared against the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got %0h, expected no output", out_data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL out_data: got %0h, expected %0h", out_data, e);
        end
      end
    end
  end

  // Offer one byte until accepted; records the stripped value the consumer must see.
  task automatic send(input logic [7:0] b, input logic [7:0] exp);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end
    if (acc) sb.push_back(exp);
    else chk("send_timeout", 32'(acc), 32'd1);
    #1;
    in_valid = 1'b0;
  endtask

  // Let the FIFO empty with the consumer ready, bounded.
  task automatic drain();
    logic done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (!out_valid) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("drain_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a;
    int         acc_n;
    logic [7:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #1;
    chk("rst_level",      32'(level),      32'd0);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_in_ready",   32'(in_ready),   32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic strip with consumer always ready; first byte visible one cycle after push.
    out_ready = 1'b1;
    send(8'h10, 8'h00);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    send(8'h11, 8'h01);
    send(8'h8F, 8'h7F);
    drain();
    chk("count_after_3", 32'(byte_count), 32'd3);

    // Modulo-256 wrap on subtraction.
    send(8'h05, 8'hF5);
    send(8'h00, 8'hF0);
    drain();
    chk("count_after_5", 32'(byte_count), 32'd5);
    chk("level_empty", 32'(level), 32'd0);

    // Backpressure: six offered, four accepted.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc_n     = 0;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'hA0 + 8'(i);
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      if (a) begin
        acc_n++;
        sb.push_back(8'h90 + 8'(i));
      end
      #1;
      if (i == 3) chk("in_ready_after_4th", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("accepted", 32'(acc_n), 32'd4);
    chk("level_full", 32'(level), 32'd4);
    @(negedge clk);
    held = out_data;
    @(negedge clk);
    chk("hold_stable", 32'(out_data), 32'(held));
    chk("hold_value",  32'(out_data), 32'h90);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_before_pop", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("in_ready_after_pop", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Full with simultaneous push/pop, then steady streaming through the wrap.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i), 8'hA0 + 8'(i));
    chk("level_4", 32'(level), 32'd4);
    in_valid = 1'b1; in_data = 8'hB4; out_ready = 1'b1;
    @(negedge clk);
    chk("full_push_refused", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 chk("level_after_pop_only", 32'(level), 32'd3);
    @(negedge clk);
    chk("in_ready_at_3", 32'(in_ready), 32'd1);
    @(posedge clk);
    sb.push_back(8'hA4);
    #1 chk("level_push_pop", 32'(level), 32'd3);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) send(8'hC0 + 8'(i), 8'hB0 + 8'(i));
    chk("level_stream", 32'(level), 32'd3);
    drain();

    // Reset with data in flight: clears without a clock edge.
    out_ready = 1'b0;
    send(8'h31, 8'h21);
    send(8'h32, 8'h22);
    send(8'h33, 8'h23);
    chk("level_3", 32'(level), 32'd3);
    rst_n = 1'b0;
    #2;
    chk("midrst_out_valid",  32'(out_valid),  32'd0);
    chk("midrst_level",      32'(level),      32'd0);
    chk("midrst_in_ready",   32'(in_ready),   32'd0);
    chk("midrst_byte_count", 32'(byte_count), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'h20, 8'h10);
    drain();
    chk("count_after_rst", 32'(byte_count), 32'd1);

    // Saturation: 65540 further pops must leave the counter at all-ones.
    for (int i = 0; i < 65540; i++) send(8'h10 + 8'(i), 8'(i));
    drain();
    chk("count_saturated", 32'(byte_count), 32'hFFFF);
    send(8'h55, 8'h45);
    drain();
    chk("count_stays_sat", 32'(byte_count), 32'hFFFF);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
